// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32 control path: FSM states,
// opcode classes, opcode constants and the datapath select encodings.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_I      = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_JAL    = 3'd5,
    CLS_JALR   = 3'd6
  } cls_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Immediate-generator format select, shared with the immediate generator.
  typedef enum logic [2:0] {
    IMM_R  = 3'd0,
    IMM_I  = 3'd1,
    IMM_S  = 3'd2,
    IMM_SB = 3'd3,
    IMM_UJ = 3'd4
  } imm_type_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10
  } pc_sel_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10
  } wb_sel_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_CMP   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  function automatic imm_type_e imm_type_of(input logic [6:0] op);
    imm_type_e t;
    case (op)
      OP_I, OP_LOAD, OP_JALR: t = IMM_I;
      OP_STORE:               t = IMM_S;
      OP_BRANCH:              t = IMM_SB;
      OP_JAL:                 t = IMM_UJ;
      default:                t = IMM_R;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_opcode_class_dec.sv
// Combinational opcode classifier: maps instruction[6:0] to an instruction
// class and flags any opcode outside the supported RV32I subset.
module opcode_class_dec
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output cls_e       cls_o,
  output logic       illegal_o
);

  // Opcode to class lookup; unknown opcodes report illegal and class R.
  always_comb begin
    cls_o     = CLS_R;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_R:      cls_o = CLS_R;
      OP_I:      cls_o = CLS_I;
      OP_LOAD:   cls_o = CLS_LOAD;
      OP_STORE:  cls_o = CLS_STORE;
      OP_BRANCH: cls_o = CLS_BRANCH;
      OP_JAL:    cls_o = CLS_JAL;
      OP_JALR:   cls_o = CLS_JALR;
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Optional memory-wait watchdog enabled by defining CTRL_TIMEOUT_EN; without
// it, handshake waits are unbounded and timeout is tied low.
module multi_cycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  input  logic        branch_taken,
  output logic        ir_we,
  output logic        pc_we,
  output logic        reg_we,
  output logic [1:0]  pc_sel,
  output logic [1:0]  wb_sel,
  output logic        alu_src_imm,
  output logic [1:0]  alu_op,
  output logic [2:0]  imm_type,
  output logic        illegal,
  output logic        timeout
);

  state_e state_q;
  cls_e   cls_q;
  logic   illegal_q;
  cls_e   dec_cls;
  logic   dec_illegal;

  logic unused_instr_hi;
  assign unused_instr_hi = ^instruction[31:7];

  opcode_class_dec u_dec (
    .opcode_i  (instruction[6:0]),
    .cls_o     (dec_cls),
    .illegal_o (dec_illegal)
  );

  assign imm_type = imm_type_of(instruction[6:0]);
  assign illegal  = illegal_q;

`ifdef CTRL_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             timeout_q;
  logic             wait_expired;
  assign wait_expired = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout      = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout            = 1'b0;
`endif

  // State sequencing, class latch, sticky flags and the optional wait counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cls_q     <= CLS_R;
      illegal_q <= 1'b0;
`ifdef CTRL_TIMEOUT_EN
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
`ifdef CTRL_TIMEOUT_EN
      // Counter only survives consecutive wait cycles; any other cycle clears it.
      wait_cnt_q <= '0;
`endif
      case (state_q)
        S_FETCH: begin
          if (imem_ack) state_q <= S_DECODE;
`ifdef CTRL_TIMEOUT_EN
          else if (wait_expired) begin
            state_q   <= S_TRAP;
            timeout_q <= 1'b1;
          end else wait_cnt_q <= wait_cnt_q + 1'b1;
`endif
        end
        S_DECODE: begin
          if (dec_illegal) begin
            state_q   <= S_TRAP;
            illegal_q <= 1'b1;
          end else begin
            cls_q   <= dec_cls;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (cls_q)
            CLS_LOAD, CLS_STORE: state_q <= S_MEM;
            CLS_BRANCH:          state_q <= S_FETCH;
            default:             state_q <= S_WB;
          endcase
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (cls_q == CLS_LOAD) state_q <= S_WB;
            else                   state_q <= S_FETCH;
          end
`ifdef CTRL_TIMEOUT_EN
          else if (wait_expired) begin
            state_q   <= S_TRAP;
            timeout_q <= 1'b1;
          end else wait_cnt_q <= wait_cnt_q + 1'b1;
`endif
        end
        S_WB:    state_q <= S_FETCH;
        S_TRAP:  state_q <= S_TRAP;
        default: state_q <= S_TRAP;
      endcase
    end
  end

  // Control outputs decoded from state; ack/branch-dependent enables must act
  // in the same cycle, so outputs are decoded rather than registered and are
  // gated by rst_n so nothing is requested or written while reset is held.
  always_comb begin
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    reg_we      = 1'b0;
    pc_sel      = PC_PLUS4;
    wb_sel      = WB_ALU;
    alu_src_imm = 1'b0;
    alu_op      = ALU_ADD;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ack;
        end
        S_EXEC: begin
          case (cls_q)
            CLS_R: alu_op = ALU_FUNCT;
            CLS_I: begin
              alu_op      = ALU_FUNCT;
              alu_src_imm = 1'b1;
            end
            CLS_LOAD, CLS_STORE: begin
              alu_op      = ALU_ADD;
              alu_src_imm = 1'b1;
            end
            CLS_BRANCH: begin
              alu_op = ALU_CMP;
              pc_we  = 1'b1;
              pc_sel = branch_taken ? PC_BRANCH : PC_PLUS4;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (cls_q == CLS_STORE);
          pc_we    = dmem_ack && (cls_q == CLS_STORE);
        end
        S_WB: begin
          reg_we = 1'b1;
          pc_we  = 1'b1;
          case (cls_q)
            CLS_LOAD: wb_sel = WB_LOAD;
            CLS_JAL: begin
              wb_sel = WB_PC4;
              pc_sel = PC_BRANCH;
            end
            CLS_JALR: begin
              wb_sel = WB_PC4;
              pc_sel = PC_JALR;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: a driver issues instructions with
// random handshake waits and pushes the expected retirement record; a monitor
// rebuilds each instruction's observed record and compares on pc_we.
`timescale 1ns/1ps
module tb_multi_cycle_ctrl;
  import riscv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instruction = '0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        branch_taken = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we;
  logic [1:0]  pc_sel, wb_sel, alu_op;
  logic        alu_src_imm;
  logic [2:0]  imm_type;
  logic        illegal, timeout;

  always #5 clk = ~clk;

  multi_cycle_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .branch_taken(branch_taken),
    .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we),
    .pc_sel(pc_sel), .wb_sel(wb_sel), .alu_src_imm(alu_src_imm), .alu_op(alu_op),
    .imm_type(imm_type), .illegal(illegal), .timeout(timeout)
  );

  int n_asserts = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_asserts++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected per-instruction record; lat counts cycles with ir_we as cycle 1.
  typedef struct {
    int lat; int ireq; int pc_sel; int reg_we; int wb_sel;
    int dreq; int dwe; int alu_op; int alu_src; int imm;
  } exp_t;

  exp_t sb_q[$];

  // Transaction-level reference: outcome of one instruction from its opcode
  // class and the handshake waits it will see.
  function automatic exp_t model(input logic [6:0] op, input int iw, input int dw, input bit bt);
    exp_t e;
    e.lat = 4; e.ireq = iw + 1; e.pc_sel = 0; e.reg_we = 1; e.wb_sel = 0;
    e.dreq = 0; e.dwe = 0; e.alu_op = 0; e.alu_src = 0; e.imm = int'(IMM_R);
    case (op)
      7'b0110011: e.alu_op = 2;
      7'b0010011: begin e.alu_op = 2; e.alu_src = 1; e.imm = int'(IMM_I); end
      7'b0000011: begin
        e.lat = 5 + dw; e.wb_sel = 1; e.dreq = dw + 1; e.alu_src = 1; e.imm = int'(IMM_I);
      end
      7'b0100011: begin
        e.lat = 4 + dw; e.reg_we = 0; e.dreq = dw + 1; e.dwe = 1; e.alu_src = 1;
        e.imm = int'(IMM_S);
      end
      7'b1100011: begin
        e.lat = 3; e.reg_we = 0; e.pc_sel = bt ? 1 : 0; e.alu_op = 1; e.imm = int'(IMM_SB);
      end
      7'b1101111: begin e.pc_sel = 1; e.wb_sel = 2; e.imm = int'(IMM_UJ); end
      7'b1100111: begin e.pc_sel = 2; e.wb_sel = 2; e.imm = int'(IMM_I); end
      default: ;
    endcase
    return e;
  endfunction

  // Monitor state
  bit   mon_en = 1'b0;
  bit   m_act = 1'b0;
  int   m_cyc, m_ireq, m_ireq_snap, m_dreq, m_dwe, m_reg, m_imm, m_alu, m_src;
  exp_t m_e;

  always @(negedge clk) begin
    if (!mon_en) begin
      m_act  = 1'b0;
      m_ireq = 0;
    end else begin
      if (imem_req) m_ireq++;
      if (ir_we) begin
        m_act = 1'b1; m_cyc = 1; m_ireq_snap = m_ireq; m_ireq = 0;
        m_dreq = 0; m_dwe = 0; m_reg = 0;
      end else if (m_act) m_cyc++;
      if (m_act) begin
        if (m_cyc == 2) m_imm = int'(imm_type);
        if (m_cyc == 3) begin m_alu = int'(alu_op); m_src = int'(alu_src_imm); end
        if (dmem_req) m_dreq++;
        if (dmem_we) m_dwe = 1;
        if (reg_we) m_reg++;
        if (pc_we) begin
          if (sb_q.size() == 0) chk("sb_unexpected_retire", 1, 0);
          else begin
            m_e = sb_q.pop_front();
            chk("latency", m_cyc, m_e.lat);
            chk("imem_req_cycles", m_ireq_snap, m_e.ireq);
            chk("pc_sel", int'(pc_sel), m_e.pc_sel);
            chk("reg_we_at_retire", int'(reg_we), m_e.reg_we);
            chk("reg_we_cycles", m_reg, m_e.reg_we);
            chk("wb_sel", int'(wb_sel), m_e.wb_sel);
            chk("dmem_req_cycles", m_dreq, m_e.dreq);
            chk("dmem_we", m_dwe, m_e.dwe);
            chk("alu_op", m_alu, m_e.alu_op);
            chk("alu_src_imm", m_src, m_e.alu_src);
            chk("imm_type", m_imm, m_e.imm);
          end
          m_act = 1'b0;
        end
      end else if (pc_we || reg_we) begin
        chk("write_without_fetch", 1, 0);
      end
    end
  end

  // Driver: answers imem/dmem requests after the chosen waits, toggling
  // acks randomly whenever no request is pending.
  task automatic issue(input logic [31:0] ins, input int iw, input int dw, input bit bt);
    int k;
    bit done;
    sb_q.push_back(model(ins[6:0], iw, dw, bt));
    k = 0; done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(posedge clk); #1;
      imem_ack = 1'b0;
      dmem_ack = 1'($urandom_range(0, 1));
      if (imem_req) begin
        if (k == iw) begin
          imem_ack = 1'b1; instruction = ins; branch_taken = bt; done = 1'b1;
        end else k++;
      end else imem_ack = 1'($urandom_range(0, 1));
    end
    if (!done) chk("fetch_handshake_bound", 0, 1);
    if (ins[6:0] == 7'b0000011 || ins[6:0] == 7'b0100011) begin
      k = 0; done = 1'b0;
      for (int t = 0; t < 200 && !done; t++) begin
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        imem_ack = 1'($urandom_range(0, 1));
        if (dmem_req) begin
          if (k == dw) begin dmem_ack = 1'b1; done = 1'b1; end
          else k++;
        end else dmem_ack = 1'($urandom_range(0, 1));
      end
      if (!done) chk("dmem_handshake_bound", 0, 1);
    end
  endtask

  task automatic fetch_one(input logic [31:0] ins);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(posedge clk); #1;
      imem_ack = 1'b0; dmem_ack = 1'b0;
      if (imem_req) begin imem_ack = 1'b1; instruction = ins; ok = 1'b1; end
    end
    if (!ok) chk("fetch_one_bound", 0, 1);
  endtask

  logic [6:0] ops [7];
  int         cnt;
  logic [31:0] rins;

  initial begin
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011; ops[3] = 7'b0100011;
    ops[4] = 7'b1100011; ops[5] = 7'b1101111; ops[6] = 7'b1100111;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", int'({imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we}), 0);
    chk("reset_illegal", int'(illegal), 0);
    chk("reset_timeout", int'(timeout), 0);
    rst_n = 1'b1; #1;
    chk("imem_req_after_reset", int'(imem_req), 1);
    mon_en = 1'b1;

    // Directed examples, then random traffic
    issue(32'h002081B3, 0, 0, 1'b0);
    issue(32'h0000A183, 0, 3, 1'b0);
    issue(32'h00208463, 0, 0, 1'b1);
    issue(32'h00208463, 0, 0, 1'b0);
    issue(32'h0020A023, 0, 0, 1'b0);
    issue(32'h008000EF, 1, 0, 1'b0);
    issue(32'h000080E7, 0, 0, 1'b0);
    issue(32'h00108093, 2, 0, 1'b0);
    for (int n = 0; n < 60; n++) begin
      rins = $urandom;
      rins[6:0] = ops[$urandom_range(0, 6)];
      issue(rins, $urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end
    for (int t = 0; t < 50 && sb_q.size() != 0; t++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    mon_en = 1'b0;

    // Illegal opcode traps and holds until reset
    fetch_one(32'h0000007F);
    @(posedge clk); #1; imem_ack = 1'b0;
    @(negedge clk);
    chk("illegal_decode_imm_type", int'(imm_type), int'(IMM_R));
    chk("illegal_flag_in_decode", int'(illegal), 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      imem_ack = 1'($urandom_range(0, 1)); dmem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("trap_outputs", int'({imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we}), 0);
      chk("trap_illegal", int'(illegal), 1);
    end
    imem_ack = 1'b0; dmem_ack = 1'b0; rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("illegal_cleared_by_reset", int'(illegal), 0);
    rst_n = 1'b1; #1;
    chk("imem_req_after_trap_reset", int'(imem_req), 1);

    // Reset during store MEM wait abandons the access
    fetch_one(32'h0020A023);
    @(posedge clk); #1; imem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("sw_mem_req", int'({dmem_req, dmem_we}), 3);
    rst_n = 1'b0; dmem_ack = 1'b1;
    @(negedge clk);
    chk("rst_in_mem_no_write", int'({pc_we, reg_we}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; dmem_ack = 1'b0;
    @(negedge clk);
    chk("after_mem_reset_fetch", int'(imem_req), 1);
    chk("after_mem_reset_idle", int'({dmem_req, pc_we, reg_we}), 0);

    // Fetch wait with no ack: watchdog trap or unbounded wait
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; #1;
    cnt = imem_req ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (imem_req) cnt++;
    end
`ifdef CTRL_TIMEOUT_EN
    chk("timeout_wait_cycles", cnt, 16);
    chk("timeout_flag", int'(timeout), 1);
`else
    chk("unbounded_wait_cycles", cnt, 101);
    chk("timeout_flag", int'(timeout), 0);
`endif
    chk("timeout_no_illegal", int'(illegal), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, max wait cycles for a memory ack (used only with CTRL_TIMEOUT_EN).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 instruction  in  32  instruction-register output, stable from DECODE until the next FETCH.
REQ-005 imem_req  out  1 / imem_ack  in  1  instruction-fetch handshake.
REQ-006 dmem_req  out  1 / dmem_we  out  1 / dmem_ack  in  1  data-memory handshake.
REQ-007 branch_taken  in  1  ALU branch-compare result, valid in EXEC.
REQ-008 ir_we, pc_we, reg_we  out  1 each  register write enables.
REQ-009 pc_sel  out  2  00 PC+4, 01 branch/JAL target, 10 JALR target.
REQ-010 wb_sel  out  2  00 ALU, 01 load data, 10 PC+4.
REQ-011 alu_src_imm  out  1  ALU operand B = immediate; alu_op  out  2  00 add, 01 compare, 10 funct-decoded.
REQ-012 imm_type  out  3  immediate-generator format select: R, I, S, SB, UJ.
REQ-013 illegal  out  1  sticky illegal-opcode flag; timeout  out  1  sticky memory-timeout flag.

Function
REQ-014 States SHALL be FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-015 FETCH: imem_req=1 until imem_ack; on ack, same cycle: ir_we=1, next state DECODE; zero-wait ack in the first FETCH cycle SHALL be accepted.
REQ-016 DECODE: opcode is classified and latched; R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111; any other opcode -> TRAP; otherwise -> EXEC.
REQ-017 imm_type SHALL decode combinationally from instruction[6:0]: I for I-ALU/LOAD/JALR, S for STORE, SB for BRANCH, UJ for JAL, R otherwise.
REQ-018 EXEC: R -> alu_op=10, alu_src_imm=0, then WB; I-ALU -> alu_op=10, alu_src_imm=1, then WB; LOAD/STORE -> alu_op=00, alu_src_imm=1, then MEM.
REQ-019 EXEC BRANCH: alu_op=01, pc_we=1, pc_sel=01 if branch_taken else 00, then FETCH.
REQ-020 EXEC JAL/JALR: no ALU use, then WB.
REQ-021 MEM: dmem_req=1 (dmem_we=1 for STORE) until dmem_ack; on ack, LOAD -> WB; STORE -> pc_we=1, pc_sel=00, then FETCH.
REQ-022 WB: reg_we=1 and pc_we=1, one cycle; wb_sel 00/pc_sel 00 for R/I-ALU, wb_sel 01/pc_sel 00 for LOAD, wb_sel 10/pc_sel 01 for JAL, wb_sel 10/pc_sel 10 for JALR; then FETCH.
REQ-023 Latency with zero-wait memory: R/I/JAL/JALR 4 cycles, LOAD 5, STORE 4, BRANCH 3.
REQ-024 TRAP: all enables and requests 0; SHALL hold until reset.
REQ-025 Acks arriving outside their wait state SHALL be ignored; all unlisted outputs SHALL be 0 in each state.

Reset
REQ-026 While rst_n=0 at a rising edge: state -> FETCH, illegal=0, timeout=0, timeout counter=0, latched class=R.
REQ-027 All enables and requests SHALL be 0 during reset; imem_req SHALL assert in the first cycle after rst_n rises.
REQ-028 Reset asserted during MEM/FETCH wait SHALL abandon the transaction with no pc_we/reg_we.

Configuration
REQ-029 Macro CTRL_TIMEOUT_EN defined: counter clears on entry to FETCH/MEM and increments each wait cycle; if no ack after TIMEOUT_CYCLES wait cycles -> TRAP, timeout=1.
REQ-030 Macro undefined: no counter; waits are unbounded; timeout tied 0.

Structure
REQ-031 Shared package riscv_ctrl_pkg SHALL hold the state enum, opcode constants, imm_type/pc_sel/wb_sel/alu_op encodings; the immediate generator SHALL use the same imm_type enum.
REQ-032 One sub-module opcode_class_dec (opcode -> class + illegal), combinational.

Verification
REQ-033 ADD 0x002081B3, zero-wait acks -> ir_we cycle 1, reg_we and pc_we with pc_sel=00 in cycle 4, imm_type=R.
REQ-034 LW 0x0000A183, dmem_ack after 3 wait cycles -> dmem_req high for 4 cycles, dmem_we=0, WB wb_sel=01; total 8 cycles.
REQ-035 BEQ 0x00208463, branch_taken=1, then 0 -> pc_we with pc_sel=01, then 00, cycle 3; reg_we never asserted.
REQ-036 Opcode 0x7F -> TRAP after DECODE, illegal=1, imem_req stays 0 until rst_n pulse.
REQ-037 rst_n low during MEM of SW 0x0020A023 -> next cycle FETCH, dmem_req=0, no pc_we.
REQ-038 CTRL_TIMEOUT_EN defined, imem_ack held 0 -> TRAP after 16 wait cycles, timeout=1; undefined -> still FETCH after 100 cycles, timeout=0.
